dual_mode_modsub_pipe: RTL and testbench
========================================

Name: dual_mode_modsub_pipe

Overview:
- Pipelined modular butterfly partner to the existing 4-lane adder.
- Performs the complementary operation in each mode:
  - Kyber (mode 0): two independent 12-bit lanes, each computing (a − b) mod 3329.
  - Dilithium (mode 1): one 24-bit lane computing (a + b) mod 8380417.
- Optional divide-by-2 mod q for INTT scaling.
- Sits between the NTT memory read port and the write-back path, with valid/ready flow control.

Parameters:
- KQ, 3329, Kyber modulus.
- DQ, 8380417, Dilithium modulus.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- in_a  in  24  operand A; mode 0 packs {lane1[23:12], lane0[11:0]}
- in_b  in  24  operand B; same packing as in_a
- in_mode  in  1  0 = Kyber dual 12-bit subtract, 1 = Dilithium 24-bit add
- in_half  in  1  1 = multiply result by 2^-1 mod q
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  24  result; mode 0 packed {lane1, lane0}
- op_cnt  out  CNT_W  results delivered since reset or clear
- cnt_clr  in  1  synchronous clear of op_cnt

Behaviour:
- Operand range: each Kyber lane is in [0, KQ); each Dilithium operand is in [0, DQ). Out-of-range inputs are undefined behaviour; no checking.
- Handshake and stall:
  - Transfer in when in_valid & in_ready. Transfer out when out_valid & out_ready.
  - Global enable en = !out_valid | out_ready. in_ready = en (combinational).
  - All stage registers load only when en. Bubbles advance when en.
- Latency: exactly 2 cycles from the accepting edge to out_valid with no stall. Throughput is 1 op per cycle.
- Stage 1 (registered: v1, mode1, half1, r1):
  - Mode 0, per lane: 13-bit d = a − b. If borrow, r = d + KQ, else r = d[11:0]. Lanes are fully independent; no carry crosses bit 12.
  - Mode 1: 25-bit s = a + b. t = s − DQ. r = t if t ≥ 0, else s[23:0].
- Stage 2 (registered: out_valid, out_data):
  - half1 = 0: out_data = r1.
  - half1 = 1, per lane (mode 0) or whole word (mode 1):
    - r even: r >> 1.
    - r odd: (r + q) >> 1, computed in 13 bits (Kyber) or 25 bits (Dilithium).
  - Result is always in [0, q).
- Mode and half flags travel with their data. Mixing modes on back-to-back cycles is legal, with no flush and no penalty.
- op_cnt:
  - Increments on each output transfer and wraps at 2^CNT_W.
  - cnt_clr takes priority over increment in the same cycle.
- Reset (any time, including mid-operation):
  - v1 = 0, out_valid = 0, out_data = 0, r1 = 0, op_cnt = 0.
  - In-flight operations are discarded.
  - in_ready = 1 after reset, because out_valid = 0.
- While out_valid = 1 and out_ready = 0:
  - out_data holds stable.
  - in_ready = 0.
  - Stage 1 is frozen.
- Simultaneous out transfer and in transfer in the same cycle: both occur, and the pipeline shifts.

Decomposition:
- Shared package holds:
  - KQ and DQ constants.
  - Mode encoding: MODE_KYBER = 0, MODE_DIL = 1.
  - Lane width constants: 12 and 24.
- One natural sub-module: mod_half_lane, parameterised on width and modulus. Instantiate it twice for Kyber (12-bit) and once for Dilithium (24-bit), muxed by mode in stage 2.

Test Plan:
1. Mode 0, half = 0, a = {100, 5}, b = {50, 10}, out_ready = 1 → out_data = {50, 3324}, out_valid exactly 2 cycles after accept, op_cnt = 1.
2. Mode 1, half = 0, a = 8380416, b = 2 → 1. Also a = 3, b = 4 → 7.
3. Mode 1, half = 1, a = 1, b = 0 → 4190209. Also a = 4, b = 2 → 3.
4. Mode 0, half = 1, a = {4, 3}, b = {2, 0} → {1, 1666}. Then, on the next cycle, a mode 1 op with a = 10, b = 0, half = 0 → 10, with no bubble.
5. Backpressure: stream 4 ops with out_ready = 0 for 3 cycles.
   - in_ready drops once out_valid = 1.
   - out_data stays stable.
   - After release, all 4 results arrive in order, with none lost or duplicated; op_cnt = 4.
6. Reset mid-flight: assert rst with 2 ops in the pipeline → out_valid = 0 and out_data = 0 asynchronously, op_cnt = 0, in_ready = 1 after release. cnt_clr together with an output transfer → op_cnt = 0.

Source files
------------

// File: rtl/dual_mode_modsub_pipe_pkg.sv
// Shared constants and types for the dual-mode modular subtract/add pipe.
// Moduli, lane widths, mode encoding and the stage-1 bundle.
package dual_mode_modsub_pipe_pkg;

  localparam int KQ = 3329;
  localparam int DQ = 8380417;

  localparam int KW = 12;
  localparam int DW = 24;

  typedef enum logic {
    MODE_KYBER = 1'b0,
    MODE_DIL   = 1'b1
  } mode_e;

  typedef struct packed {
    logic          v;
    mode_e         mode;
    logic          half;
    logic [DW-1:0] r;
  } s1_t;

endpackage

// File: rtl/mod_half_lane.sv
// Multiply a reduced value by 2^-1 mod Q (Q odd).
// Ports: r = value in [0, Q), h = r * 2^-1 mod Q.
module mod_half_lane #(
  parameter int W = 12,
  parameter int Q = 3329
) (
  input  logic [W-1:0] r,
  output logic [W-1:0] h
);

  localparam logic [W:0] QW = (W+1)'(Q);

  // One extra bit so r + Q cannot overflow before the shift.
  logic [W:0] sum;

  assign sum = {1'b0, r} + QW;
  assign h   = r[0] ? sum[W:1] : {1'b0, r[W-1:1]};

endmodule

// File: rtl/dual_mode_modsub_pipe.sv
// Two-stage modular butterfly partner: dual 12-bit (a-b) mod KQ or
// 24-bit (a+b) mod DQ, optional halving, valid/ready flow control.
// Ports: clk, rst (async high); in_valid/in_ready/in_a/in_b/in_mode/
// in_half; out_valid/out_ready/out_data; op_cnt with cnt_clr.
module dual_mode_modsub_pipe
  import dual_mode_modsub_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  input  logic             in_mode,
  input  logic             in_half,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [CNT_W-1:0] op_cnt,
  input  logic             cnt_clr
);

  localparam logic [KW-1:0] KQ_V = KW'(KQ);
  localparam logic [DW+1:0] DQ_V = (DW+2)'(DQ);

  logic en;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1: Kyber lanes subtract independently.
  logic [KW:0]   d0;
  logic [KW:0]   d1;
  logic [KW-1:0] k0;
  logic [KW-1:0] k1;

  assign d0 = {1'b0, in_a[KW-1:0]} - {1'b0, in_b[KW-1:0]};
  assign d1 = {1'b0, in_a[DW-1:KW]} - {1'b0, in_b[DW-1:KW]};
  // On borrow the low 12 bits hold a-b+4096; adding KQ mod 4096
  // yields a-b+KQ.
  assign k0 = d0[KW] ? d0[KW-1:0] + KQ_V : d0[KW-1:0];
  assign k1 = d1[KW] ? d1[KW-1:0] + KQ_V : d1[KW-1:0];

  // Stage 1: Dilithium add with a single conditional subtract.
  logic [DW:0]   s;
  logic [DW+1:0] t;
  logic [DW-1:0] dr;

  assign s  = {1'b0, in_a} + {1'b0, in_b};
  assign t  = {1'b0, s} - DQ_V;
  assign dr = t[DW+1] ? s[DW-1:0] : t[DW-1:0];

  s1_t s1_d;
  s1_t s1_q;

  always_comb begin
    s1_d      = '0;
    s1_d.v    = in_valid;
    s1_d.mode = mode_e'(in_mode);
    s1_d.half = in_half;
    unique case (1'b1)
      (in_mode == MODE_DIL): s1_d.r = dr;
      default:               s1_d.r = {k1, k0};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
    end else if (en) begin
      s1_q <= s1_d;
    end
  end

  // Stage 2: optional halving, per lane or whole word.
  logic [KW-1:0] h0;
  logic [KW-1:0] h1;
  logic [DW-1:0] hd;
  logic [DW-1:0] res;

  mod_half_lane #(.W(KW), .Q(KQ)) u_half_k0 (
    .r (s1_q.r[KW-1:0]),
    .h (h0)
  );

  mod_half_lane #(.W(KW), .Q(KQ)) u_half_k1 (
    .r (s1_q.r[DW-1:KW]),
    .h (h1)
  );

  mod_half_lane #(.W(DW), .Q(DQ)) u_half_d (
    .r (s1_q.r),
    .h (hd)
  );

  always_comb begin
    res = s1_q.r;
    if (s1_q.half) begin
      unique case (1'b1)
        (s1_q.mode == MODE_DIL): res = hd;
        default:                 res = {h1, h0};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= s1_q.v;
      out_data  <= res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cnt <= '0;
    end else if (cnt_clr) begin
      op_cnt <= '0;
    end else if (out_valid && out_ready) begin
      op_cnt <= op_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dual_mode_modsub_pipe.sv
// Directed self-checking bench for dual_mode_modsub_pipe.
// One task per scenario, inline comparisons, single summary line.
module tb_dual_mode_modsub_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_a;
  logic [23:0] in_b;
  logic        in_mode;
  logic        in_half;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [15:0] op_cnt;
  logic        cnt_clr;

  int n_chk;
  int n_fail;

  dual_mode_modsub_pipe #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_half   (in_half),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .op_cnt    (op_cnt),
    .cnt_clr   (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic h,
                       input logic [23:0] a, input logic [23:0] b);
    in_valid = 1'b1;
    in_mode  = m;
    in_half  = h;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic idle;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_mode  = 1'b0;
    in_half  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle();
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    #12;
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== 24'd0 ||
        op_cnt !== 16'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: v=%b d=%0d cnt=%0d rdy=%b want 0 0 0 1",
               out_valid, out_data, op_cnt, in_ready);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_kyber_sub;
    drive(1'b0, 1'b0, {12'd100, 12'd5}, {12'd50, 12'd10});
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL kyb_rdy: got %b want 1", in_ready);
    end
    tick();
    idle();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL kyb_early: out_valid %b want 0", out_valid);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== {12'd50, 12'd3324}) begin
      n_fail++;
      $display("FAIL kyb_sub: v=%b d=%h want 1 %h",
               out_valid, out_data, {12'd50, 12'd3324});
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || op_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL kyb_cnt: v=%b cnt=%0d want 0 1", out_valid, op_cnt);
    end
  endtask

  task automatic test_dil_add;
    drive(1'b1, 1'b0, 24'd8380416, 24'd2);
    tick();
    drive(1'b1, 1'b0, 24'd3, 24'd4);
    tick();
    idle();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 24'd1) begin
      n_fail++;
      $display("FAIL dil_wrap: v=%b d=%0d want 1 1", out_valid, out_data);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 24'd7) begin
      n_fail++;
      $display("FAIL dil_add: v=%b d=%0d want 1 7", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_dil_half;
    drive(1'b1, 1'b1, 24'd1, 24'd0);
    tick();
    drive(1'b1, 1'b1, 24'd4, 24'd2);
    tick();
    idle();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 24'd4190209) begin
      n_fail++;
      $display("FAIL dil_half_odd: v=%b d=%0d want 1 4190209",
               out_valid, out_data);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 24'd3) begin
      n_fail++;
      $display("FAIL dil_half_even: v=%b d=%0d want 1 3",
               out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_mixed;
    drive(1'b0, 1'b1, {12'd4, 12'd3}, {12'd2, 12'd0});
    tick();
    drive(1'b1, 1'b0, 24'd10, 24'd0);
    tick();
    idle();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== {12'd1, 12'd1666}) begin
      n_fail++;
      $display("FAIL kyb_half: v=%b d=%h want 1 %h",
               out_valid, out_data, {12'd1, 12'd1666});
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 24'd10) begin
      n_fail++;
      $display("FAIL mix_next: v=%b d=%0d want 1 10", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [23:0] a_v [4];
    logic [23:0] b_v [4];
    logic [23:0] e_v [4];
    logic [23:0] held;
    int sent;
    int got;
    int stalls;
    a_v = '{24'd1, 24'd2, 24'd3, 24'd4};
    b_v = '{24'd10, 24'd20, 24'd30, 24'd40};
    e_v = '{24'd11, 24'd22, 24'd33, 24'd44};
    sent   = 0;
    got    = 0;
    stalls = 0;
    held   = '0;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      out_ready = (stalls >= 3);
      if (sent < 4) drive(1'b1, 1'b0, a_v[sent], b_v[sent]);
      else idle();
      #1;
      if (out_valid && !out_ready) begin
        n_chk++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_rdy: in_ready %b want 0", in_ready);
        end
        if (stalls > 0) begin
          n_chk++;
          if (out_data !== held) begin
            n_fail++;
            $display("FAIL bp_hold: d=%0d want %0d", out_data, held);
          end
        end
        held = out_data;
        stalls++;
      end
      if (out_valid && out_ready) begin
        n_chk++;
        if (out_data !== e_v[got]) begin
          n_fail++;
          $display("FAIL bp_order%0d: d=%0d want %0d",
                   got, out_data, e_v[got]);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    idle();
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (got !== 4 || op_cnt !== 16'd4 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_total: got=%0d cnt=%0d v=%b want 4 4 0",
               got, op_cnt, out_valid);
    end
    tick();
  endtask

  task automatic test_reset_midflight;
    drive(1'b1, 1'b0, 24'd5, 24'd6);
    tick();
    drive(1'b1, 1'b0, 24'd7, 24'd8);
    tick();
    idle();
    rst = 1'b1;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== 24'd0 || op_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_async: v=%b d=%0d cnt=%0d want 0 0 0",
               out_valid, out_data, op_cnt);
    end
    tick();
    rst = 1'b0;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_rdy: in_ready %b want 1", in_ready);
    end
    tick();
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flush: out_valid %b want 0", out_valid);
    end
    drive(1'b1, 1'b0, 24'd1, 24'd1);
    tick();
    idle();
    tick();
    cnt_clr = 1'b1;
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 24'd2) begin
      n_fail++;
      $display("FAIL clr_pre: v=%b d=%0d want 1 2", out_valid, out_data);
    end
    tick();
    cnt_clr = 1'b0;
    n_chk++;
    if (op_cnt !== 16'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_prio: cnt=%0d v=%b want 0 0", op_cnt, out_valid);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_kyber_sub();
    test_dil_add();
    test_dil_half();
    test_mixed();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
